fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end. Successor to the plain PC register.
- Owns the program counter and issues requests to a synchronous IMEM with 1-cycle read latency.
- Buffers returned instructions in a small queue and presents them to decode over a valid/ready handshake.
- Adds stall back-pressure, branch/jump redirect with flush, and a configurable PC step for word or byte addressing.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetch. Power of two: 1 = word addressing, 4 = byte addressing.
- QDEPTH, 4, instruction queue entries. Power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; flush and restart fetch.
- redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  IMEM read request this cycle.
- imem_addr  out  XLEN  IMEM read address, equal to the current PC.
- imem_rdata  in  XLEN  IMEM data, valid the cycle after imem_req.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head.
- out_instr  out  XLEN  instruction at the queue head.
- out_pc  out  XLEN  PC of out_instr.

Behaviour:
- Reset (sync, active-high):
  - pc = RESET_PC; queue empty; in-flight flag = 0.
  - imem_req = 0, out_valid = 0, out_instr = 0, out_pc = 0.
  - A reset that lands mid-operation discards all queued and in-flight data.
- Issue:
  - imem_req = !reset && !redirect_valid && (count + inflight < QDEPTH).
  - imem_addr = pc, always driven.
  - On issue: pc <= pc + PC_STEP, modulo 2^XLEN, so 0xFFFFFFFC + 4 = 0x00000000. Record inflight = 1 and inflight_pc = pc.
- Return:
  - The cycle after an issue, imem_rdata and inflight_pc are pushed into the queue at the clock edge, unless killed.
- Pop: a handshake (out_valid && out_ready) removes the head at the edge.
  - Push and pop in the same cycle are both allowed; count stays the same.
  - Pop while empty is ignored.
- Capacity: the issue rule ensures a push never finds the queue full. Push-on-full is an assertion failure.
- Redirect has priority over everything:
  - Queue count <= 0; in-flight response dropped; out_valid = 0 next cycle.
  - pc <= redirect_pc with the low log2(PC_STEP) bits forced to 0.
  - imem_req = 0 in the redirect cycle.
- Latency:
  - Issue in cycle N, head valid in cycle N+2.
  - After reset release at cycle 0: first out_valid in cycle 2 with out_pc = RESET_PC.
  - Redirect in cycle R: first new instruction at out in cycle R+3.
- Throughput: with out_ready held high, one instruction per cycle steady state.
- Stall: out_ready = 0 lets the queue fill to QDEPTH, then imem_req drops to 0. The pc holds and no fetch is skipped.
- Outputs: out_instr and out_pc are read straight from the head entry. Contents are don't-care when out_valid = 0; the bench must not check them then.

Decomposition:
- Package fetch_pkg:
  - XLEN default.
  - RESET_PC default.
  - Function clog2.
  - Localparam for the PC alignment mask derived from PC_STEP.
- Sub-module fetch_queue: synchronous FIFO, width 2*XLEN ({pc, instr}), depth QDEPTH.
  - Ports: push/pop/flush, count, full, empty.
  - Pointers wrap modulo QDEPTH.
  - flush has priority over push.
- fetch_unit contains the PC register, in-flight tracking and issue logic.

Test Plan:
- Reset then free-run (PC_STEP=4, out_ready=1, IMEM mem[i] = i): out_pc sequence 0x0, 0x4, 0x8 … from cycle 2, one per cycle, and out_instr matches the IMEM word. Repeat with PC_STEP=1: out_pc = 0, 1, 2 ….
- Back-pressure (out_ready=0 from cycle 0, QDEPTH=4):
  - Exactly 4 issues, then imem_req=0 and pc holds at 0x10.
  - Raise out_ready: heads emerge as 0x0, 0x4, 0x8, 0xC, 0x10 with no gaps or duplicates.
- Redirect:
  - Assert redirect_valid with redirect_pc=0x100 while the queue holds 3 entries and one is in flight.
  - out_valid=0 the next cycle; the next out_pc is 0x100, 3 cycles later.
  - The stale in-flight word never appears.
- Misaligned redirect: redirect_pc=0x103 with PC_STEP=4 → fetch resumes at 0x100.
- Wrap: RESET_PC=0xFFFFFFF8 → out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-stream (queue partly full, request in flight):
  - Assert reset one cycle: next cycle out_valid=0, imem_req=0.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;
  localparam int PC_STEP_DEF = 4;
  localparam int QDEPTH_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clears the sub-step address bits so every PC lands on a fetch boundary.
  localparam logic [XLEN_DEF-1:0] PC_ALIGN_MASK_DEF = ~XLEN_DEF'(PC_STEP_DEF - 1);
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs between IMEM and decode.
module fetch_queue import fetch_pkg::*; #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && !reset;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assert property (@(posedge clk) disable iff (reset) !(do_push && full));
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single outstanding IMEM read, and a decode-facing queue.
module fetch_unit import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int PC_STEP = PC_STEP_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);
  localparam int CW = clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(PC_STEP - 1);

  logic [XLEN-1:0]   pc, inflight_pc;
  logic              inflight, push, q_empty, q_full;
  logic [CW-1:0]     count, occupancy;
  logic [2*XLEN-1:0] head;

  // Reserve a slot for the outstanding read so a return never meets a full queue.
  assign occupancy = count + CW'(inflight);
  assign imem_req  = !reset && !redirect_valid && (occupancy < CW'(QDEPTH));
  assign imem_addr = pc;
  assign push      = inflight && !redirect_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc          <= pc + XLEN'(PC_STEP);
        inflight_pc <= pc;
      end
    end
  end

  fetch_queue #(.W(2*XLEN), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (out_valid && out_ready),
    .flush (redirect_valid),
    .wdata ({inflight_pc, imem_rdata}),
    .rdata (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign out_valid          = !q_empty;
  assign {out_pc, out_instr} = q_empty ? '0 : head;

  assert property (@(posedge clk) disable iff (reset) !(push && q_full));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model checked every cycle.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;

  logic        b_req, b_valid, c_req, c_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc;
  logic [31:0] c_addr, c_rdata, c_instr, c_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(.PC_STEP(1)) dut_b (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(1'b1), .out_instr(b_instr), .out_pc(b_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_c (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(c_req), .imem_addr(c_addr), .imem_rdata(c_rdata),
    .out_valid(c_valid), .out_ready(1'b1), .out_instr(c_instr), .out_pc(c_pc)
  );

  // IMEM contents: mem[i] = i, where i is the word index of the address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
    if (b_req)    b_rdata    <= b_addr;
    if (c_req)    c_rdata    <= c_addr >> 2;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: every fetched PC in program order with its issue cycle.
  // Requests stay outstanding until decode consumes them; a head is visible
  // two cycles after issue; redirect/reset forget everything outstanding.
  typedef struct { logic [31:0] pc; int cyc; } iss_t;
  iss_t        q[$];
  logic [31:0] fptr;
  int          cyc;
  bit          started = 0;
  bit          exp_req, exp_valid;

  always @(negedge clk) begin
    if (reset) begin
      if (started) chk("model_rst_req", {31'b0, imem_req}, 32'd0);
      q.delete();
      fptr    = 32'h0;
      cyc     = 0;
      started = 1;
    end else if (started) begin
      exp_req = !redirect_valid && (q.size() < 4);
      chk("model_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (imem_req) chk("model_addr", imem_addr, fptr);
      exp_valid = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      chk("model_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid && out_valid) begin
        chk("model_pc", out_pc, q[0].pc);
        chk("model_instr", out_instr, q[0].pc >> 2);
      end
      if (redirect_valid) begin
        q.delete();
        fptr = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (exp_req) begin
          q.push_back('{fptr, cyc});
          fptr += 32'd4;
        end
      end
      cyc++;
    end
  end

  int          issues;
  logic [31:0] cpc;

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;                                  // cycle 0

    // Free-run on all three instances
    @(negedge clk);
    chk("run_c0_req", {31'b0, imem_req}, 32'd1);
    chk("run_c0_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("run_c1_valid", {31'b0, out_valid}, 32'd0);
    for (int k = 2; k < 10; k++) begin
      @(negedge clk);
      chk("run_valid", {31'b0, out_valid}, 32'd1);
      chk("run_pc", out_pc, 32'(4 * (k - 2)));
      chk("run_instr", out_instr, 32'(k - 2));
      chk("word_valid", {31'b0, b_valid}, 32'd1);
      chk("word_pc", b_pc, 32'(k - 2));
      chk("word_instr", b_instr, 32'(k - 2));
      if (k < 5) begin
        cpc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        chk("wrap_valid", {31'b0, c_valid}, 32'd1);
        chk("wrap_pc", c_pc, cpc);
        chk("wrap_instr", c_instr, cpc >> 2);
      end
    end

    // Back-pressure from cycle 0
    @(posedge clk); #1 reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0;                  // cycle 0
    issues = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (imem_req) issues++;
    end
    chk("bp_issues", 32'(issues), 32'd4);
    chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    chk("bp_pc_hold", imem_addr, 32'h10);
    @(posedge clk); #1 out_ready = 1'b1;              // cycle 8
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_drain_pc", out_pc, 32'(4 * i));
    end

    // Redirect with 3 queued and 1 in flight
    @(posedge clk); #1 reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b0;                  // cycle 0
    repeat (4) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h100;  // cycle 4
    @(negedge clk);
    chk("rd_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("rd_req_low", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1 redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rd_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("rd_target_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("rd_r2_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd_valid", {31'b0, out_valid}, 32'd1);
      chk("rd_pc", out_pc, 32'h100 + 32'(4 * i));
    end

    // Misaligned redirect target
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_valid", {31'b0, out_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    chk("mis_pc", out_pc, 32'h100);
    chk("mis_instr", out_instr, 32'h40);

    // Reset mid-stream with a partly full queue and a read in flight
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_pc0", out_pc, 32'h0);
    @(negedge clk);
    chk("mr_pc1", out_pc, 32'h4);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
